hex_scan_display: RTL and testbench

HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

---
 rtl/hex_scan_display.sv | 115 +++++++++++
 tb/tb_hex_scan_display.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_display.sv
// Multiplexed hex display driver: captures a DIGITS-nibble value and scans it onto
// active-low segment/anode outputs. Leading-zero blanking is built only with HEX_SCAN_LZB_EN.
module hex_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  blank_lz,
    output logic                  ack,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [6:0]    SEG_OFF    = 7'h7F;

    logic [DIGITS-1:0][3:0] shadow;
    logic [PW-1:0]          presc;
    logic [IW-1:0]          idx;

    logic [3:0]             cur_nib;
    logic [6:0]             cur_seg;
    logic                   cur_blank;
    logic                   presc_tc;
    logic [DIGITS-1:0]      an_sel;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        cur_nib  = shadow[idx];
        cur_seg  = hex_to_seg(cur_nib);
        presc_tc = (presc == PRESC_LAST);
        an_sel   = DIGITS'(1) << idx;
    end

`ifdef HEX_SCAN_LZB_EN
    logic [DIGITS-1:0] lz_mask;
    logic              zero_run;

    // NOTE: zero_run is a combinational running flag, so blocking '=' with a default
    // assigned first; this keeps the loop ordered and infers no latch.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (shadow[i] == 4'h0);
            lz_mask[i] = blank_lz & zero_run;
        end
    end

    assign cur_blank = lz_mask[idx];
`else
    logic unused_blank_lz;
    assign unused_blank_lz = blank_lz;
    assign cur_blank       = 1'b0;
`endif

    // Outputs are computed from the pre-edge index and shadow, so they trail both by one cycle.
    // NOTE: all state here uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            shadow <= '0;
            presc  <= '0;
            idx    <= '0;
            ack    <= 1'b0;
            seg    <= SEG_OFF;
            an     <= '1;
        end else begin
            ack <= load;
            if (load) begin
                shadow <= data;
            end
            if (en) begin
                if (presc_tc) begin
                    presc <= '0;
                    idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
                seg <= cur_blank ? SEG_OFF : cur_seg;
                an  <= cur_blank ? '1 : ~an_sel;
            end else begin
                seg <= SEG_OFF;
                an  <= '1;
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display: a 4-digit/SCAN_DIV=2 instance and a 1-digit
// instance share stimulus; a cycle model pushes expected outputs, a monitor pops and compares.
module tb_hex_scan_display;

    localparam int T_DIGITS = 4;
    localparam int T_DIV    = 2;
`ifdef HEX_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk;
    logic        clr;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic        blank_lz;
    logic        ack;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        ack1;
    logic [6:0]  seg1;
    logic [0:0]  an1;

    hex_scan_display #(.DIGITS(T_DIGITS), .SCAN_DIV(T_DIV)) dut (
        .clk(clk), .clr(clr), .en(en), .load(load), .data(data),
        .blank_lz(blank_lz), .ack(ack), .seg(seg), .an(an)
    );

    hex_scan_display #(.DIGITS(1), .SCAN_DIV(1)) dut1 (
        .clk(clk), .clr(clr), .en(en), .load(load), .data(data[3:0]),
        .blank_lz(blank_lz), .ack(ack1), .seg(seg1), .an(an1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ack;
        logic [6:0] seg;
        logic [3:0] an;
        logic       ack1;
        logic [6:0] seg1;
        logic       an1;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // reference state for the model
    logic [15:0] m_shadow;
    int          m_presc;
    int          m_idx;
    logic [3:0]  m1_shadow;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic lz_blank(input logic [15:0] v, input int i, input logic b);
        return LZB && b && (i > 0) && ((v >> (4 * i)) == 16'h0);
    endfunction

    // Advance the model by one rising edge using the inputs just sampled.
    task automatic model_edge(input string tag);
        exp_t       e;
        logic [3:0] nib;
        logic       blk;
        if (clr) begin
            m_shadow  = '0;
            m_presc   = 0;
            m_idx     = 0;
            m1_shadow = '0;
            e.ack  = 1'b0; e.seg  = 7'h7F; e.an  = 4'hF;
            e.ack1 = 1'b0; e.seg1 = 7'h7F; e.an1 = 1'b1;
        end else begin
            nib = m_shadow[4*m_idx +: 4];
            blk = lz_blank(m_shadow, m_idx, blank_lz);
            e.ack  = load;
            e.ack1 = load;
            if (en) begin
                e.seg  = blk ? 7'h7F : SEG_TAB[nib];
                e.an   = blk ? 4'hF : ~(4'b0001 << m_idx);
                e.seg1 = SEG_TAB[m1_shadow];
                e.an1  = 1'b0;
                if (m_presc == T_DIV - 1) begin
                    m_presc = 0;
                    m_idx   = (m_idx + 1) % T_DIGITS;
                end else begin
                    m_presc++;
                end
            end else begin
                e.seg = 7'h7F; e.an = 4'hF; e.seg1 = 7'h7F; e.an1 = 1'b1;
            end
            if (load) begin
                m_shadow  = data;
                m1_shadow = data[3:0];
            end
        end
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic step(input logic c, input logic e, input logic l,
                        input logic [15:0] d, input logic b, input string tag);
        @(negedge clk);
        clr = c; en = e; load = l; data = d; blank_lz = b;
        @(posedge clk);
        model_edge(tag);
    endtask

    task automatic run(input int n, input logic e, input logic b, input string tag);
        for (int k = 0; k < n; k++) step(1'b0, e, 1'b0, 16'h0, b, tag);
    endtask

    // Monitor: outputs settle after the rising edge and are compared on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            string t;
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".ack"},  16'(ack),  16'(e.ack));
            check({t, ".seg"},  16'(seg),  16'(e.seg));
            check({t, ".an"},   16'(an),   16'(e.an));
            check({t, ".ack1"}, 16'(ack1), 16'(e.ack1));
            check({t, ".seg1"}, 16'(seg1), 16'(e.seg1));
            check({t, ".an1"},  16'(an1),  16'(e.an1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; en = 1'b1; load = 1'b0; data = '0; blank_lz = 1'b0;
        m_shadow = '0; m_presc = 0; m_idx = 0; m1_shadow = '0;

        // reset, including a load coincident with clr that must be dropped
        step(1'b1, 1'b1, 1'b0, 16'h0,    1'b0, "rst");
        step(1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b0, "rst_load");
        step(1'b1, 1'b0, 1'b0, 16'h0,    1'b0, "rst");

        // capture 1A2F and scan two full rotations
        step(1'b0, 1'b1, 1'b1, 16'h1A2F, 1'b0, "scan_load");
        run(16, 1'b1, 1'b0, "scan");

        // freeze mid-scan for 5 cycles, with a load captured while frozen
        run(3, 1'b1, 1'b0, "pre_freeze");
        run(2, 1'b0, 1'b0, "freeze");
        step(1'b0, 1'b0, 1'b1, 16'hC0DE, 1'b0, "freeze_load");
        run(2, 1'b0, 1'b0, "freeze");
        run(9, 1'b1, 1'b0, "resume");

        // back-to-back loads, last one wins
        step(1'b0, 1'b1, 1'b1, 16'h1111, 1'b0, "b2b");
        step(1'b0, 1'b1, 1'b1, 16'h9876, 1'b0, "b2b");
        run(8, 1'b1, 1'b0, "b2b_scan");

        // clr while index is 2, coincident with a load
        for (int k = 0; k < 20 && m_idx != 2; k++) run(1, 1'b1, 1'b0, "to_idx2");
        step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, "clr_mid");
        run(6, 1'b1, 1'b0, "after_clr");

        // leading-zero blanking stimulus
        step(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1, "lz_0040");
        run(9, 1'b1, 1'b1, "lz_0040");
        step(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, "lz_0000");
        run(9, 1'b1, 1'b1, "lz_0000");

        // nibble sweep, visible on the single-digit instance
        for (int v = 0; v < 16; v++) begin
            step(1'b0, 1'b1, 1'b1, 16'(v), 1'b0, "sweep");
            run(2, 1'b1, 1'b0, "sweep");
        end

        // random traffic: loads colliding with digit advances, en toggling, rare clr
        for (int k = 0; k < 200; k++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 3) == 0), 16'($urandom), 1'($urandom),
                 "random");
        end

        @(negedge clk);
        @(negedge clk);
        check("sb_drain", 16'(sb_q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
